mvu_result_collector: RTL and testbench
=======================================

Name: mvu_result_collector

Overview:
- Hardware reader for the MVU output-write side: snoops each MVU lane's result-write port and irq during a GEMV job.
- Gathers result words from the enabled lanes into one FIFO and presents them to the host with valid/ready.
- Reports job completion once every enabled lane has raised irq and all captured words have been drained.
- Sits beside mvutop on the system interface, so on-chip control (or the bench) reads results without polling MVU memories.

Parameters:
- NMVU, 8, number of MVU lanes snooped
- DATA_W, 32, result word width
- ADDR_W, 15, MVU result address width
- FIFO_DEPTH, 16, output FIFO entries (power of two, >=2)
- CNT_W, 16, width of the collected-word counter

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- cfg_start  in  1  one-cycle pulse: begin a job; honoured only in IDLE
- cfg_mask  in  NMVU  lanes to collect; sampled on an accepted cfg_start
- mvu_wr_en  in  NMVU  per-lane result-write strobe
- mvu_wr_addr  in  NMVU*ADDR_W  per-lane write address, lane i at [i*ADDR_W +: ADDR_W]
- mvu_wr_data  in  NMVU*DATA_W  per-lane write data, same packing
- mvu_irq  in  NMVU  per-lane job-done pulse
- out_valid  out  1  FIFO head valid
- out_ready  in  1  host accepts head
- out_data  out  DATA_W  head data
- out_addr  out  ADDR_W  head address
- out_lane  out  $clog2(NMVU)  head source lane
- busy  out  1  state != IDLE
- done  out  1  one-cycle completion pulse
- overflow  out  1  sticky: a result word was dropped
- count  out  CNT_W  words pushed into FIFO this job

Behaviour:
- Reset: all outputs 0; state IDLE; FIFO empty; holding registers empty; latched mask and irq_seen cleared. A reset mid-job aborts with no done pulse and discards FIFO contents.
- FSM: IDLE -> COLLECT on cfg_start. The same edge latches the mask, clears count, irq_seen and overflow, and empties all holding registers. cfg_start outside IDLE is ignored.
- COLLECT -> DRAIN when (irq_seen & mask) == mask and all holding registers are empty. A mask of 0 reaches DRAIN on the next cycle.
- DRAIN -> DONE when the FIFO is empty. DONE asserts done for exactly one cycle, then returns to IDLE.
- Capture: in COLLECT, for each masked lane with mvu_wr_en=1:
  - if the lane's 1-entry holding register is empty (or is being granted this cycle), the register loads {addr, data}.
  - otherwise the write is dropped and overflow is set.
  - Unmasked lanes and writes outside COLLECT are ignored.
- irq: mvu_irq[i] & mask[i] in COLLECT sets irq_seen[i]. An irq in the same cycle as that lane's final write is legal: the write is still captured.
- Arbiter: round-robin over non-empty holding registers, one grant per cycle, granted only when the FIFO is not full. The priority pointer advances to granted lane+1 mod NMVU. After reset, lane 0 has highest priority.
- Push: a granted entry is written to the FIFO with its lane index, and count increments. count saturates at 2^CNT_W-1.
- Latency: a write sampled at edge t sits in its holding register after t, is pushed at edge t+1, and shows out_valid after t+1 when the FIFO was empty. Minimum latency is 2 cycles.
- FIFO full: no grant; holding registers retain their data. Further writes to occupied lanes overflow.
- Simultaneous push and pop when full: the pop frees the slot, but the grant is still blocked this cycle (full is evaluated before the pop).
- Output FIFO is first-word-fall-through:
  - out_* are stable while out_valid & !out_ready.
  - pop on out_valid & out_ready.
  - out_data, out_addr and out_lane are 0 when the FIFO is empty.
- overflow stays set until the next accepted cfg_start or reset. count holds its value after done until the next accepted start.

Test Plan:
- Single lane: mask=0x01, lane 0 writes 3 words (addr 0..2, data A,B,C), then irq; out_ready=1 -> out_valid 2 cycles after first write; A,B,C in order with lane 0; count=3; done one cycle after the FIFO empties.
- Contention: mask=0x05, lanes 0 and 2 write in the same cycle for 2 cycles, then both irq -> FIFO order L0,L2,L0,L2 (round-robin); count=4; no overflow.
- Backpressure: FIFO_DEPTH=16, out_ready=0, lane 1 writes 20 consecutive words -> 16 in FIFO, 1 held, remaining writes dropped with overflow=1. Raising out_ready drains 17 words; count=17.
- Masking/ignore: mask=0x02, lane 3 writes and irqs, lane 1 irqs only -> nothing collected from lane 3; count=0; done asserted; cfg_start pulsed while busy has no effect.
- Empty mask: cfg_start with mask=0 -> done pulse 2 cycles after start; busy drops the cycle after.
- Reset mid-job: rst asserted with 5 words in the FIFO during COLLECT -> out_valid=0, busy=0, count=0 immediately (async); no done pulse.

Source files
------------

// File: rtl/mvu_result_collector_if.sv
// Host-side result stream of the MVU result collector: a first-word-fall-through
// head (data, address, source lane) with a valid/ready handshake.
interface mvu_result_collector_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 15,
    parameter int LANE_W = 3
);
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [ADDR_W-1:0] out_addr;
    logic [LANE_W-1:0] out_lane;

    modport master (
        output out_valid,
        output out_data,
        output out_addr,
        output out_lane,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_data,
        input  out_addr,
        input  out_lane,
        output out_ready
    );
endinterface

// File: rtl/mvu_result_collector.sv
// Snoops the per-lane MVU result-write ports during a GEMV job, funnels the words
// through per-lane holding registers and a round-robin arbiter into one FWFT FIFO.
module mvu_result_collector #(
    parameter int NMVU       = 8,
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 15,
    parameter int FIFO_DEPTH = 16,
    parameter int CNT_W      = 16,
    parameter int LANE_W     = (NMVU > 1) ? $clog2(NMVU) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cfg_start,
    input  logic [NMVU-1:0]          cfg_mask,
    input  logic [NMVU-1:0]          mvu_wr_en,
    input  logic [NMVU*ADDR_W-1:0]   mvu_wr_addr,
    input  logic [NMVU*DATA_W-1:0]   mvu_wr_data,
    input  logic [NMVU-1:0]          mvu_irq,
    mvu_result_collector_if.master   out_if,
    output logic                     busy,
    output logic                     done,
    output logic                     overflow,
    output logic [CNT_W-1:0]         count
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int ENT_W = LANE_W + ADDR_W + DATA_W;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_DRAIN   = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    state_t              state_r;
    logic [NMVU-1:0]     mask_r;
    logic [NMVU-1:0]     irq_seen_r;
    logic [NMVU-1:0]     hold_v_r;
    logic [ADDR_W-1:0]   hold_addr_r [NMVU];
    logic [DATA_W-1:0]   hold_data_r [NMVU];
    logic [LANE_W-1:0]   rr_ptr_r;
    logic [ENT_W-1:0]    mem_r [FIFO_DEPTH];
    logic [PTR_W:0]      wr_ptr_r;
    logic [PTR_W:0]      rd_ptr_r;

    logic                start_s;
    logic [NMVU-1:0]     cap_s;
    logic                drop_s;
    logic                fifo_empty_s;
    logic                fifo_full_s;
    logic                pop_s;
    logic                grant_any_s;
    logic [LANE_W-1:0]   grant_idx_s;
    logic [NMVU-1:0]     grant_vec_s;
    int                  idx_s;
    logic [LANE_W-1:0]   lane_s;
    logic                hit_s;
    logic [ENT_W-1:0]    head_s;

    assign start_s      = (state_r == S_IDLE) && cfg_start;
    assign cap_s        = (state_r == S_COLLECT) ? (mask_r & mvu_wr_en) : {NMVU{1'b0}};
    assign drop_s       = |(cap_s & hold_v_r & ~grant_vec_s);
    assign fifo_empty_s = (wr_ptr_r == rd_ptr_r);
    // Full when the pointers alias on the same slot but differ in the wrap bit.
    assign fifo_full_s  = (wr_ptr_r == {~rd_ptr_r[PTR_W], rd_ptr_r[PTR_W-1:0]});
    assign pop_s        = !fifo_empty_s && out_if.out_ready;
    assign head_s       = mem_r[rd_ptr_r[PTR_W-1:0]];

    assign out_if.out_valid = !fifo_empty_s;
    assign out_if.out_data  = fifo_empty_s ? {DATA_W{1'b0}} : head_s[DATA_W-1:0];
    assign out_if.out_addr  = fifo_empty_s ? {ADDR_W{1'b0}} : head_s[DATA_W +: ADDR_W];
    assign out_if.out_lane  = fifo_empty_s ? {LANE_W{1'b0}} : head_s[ENT_W-1 -: LANE_W];

    // Round-robin grant: first occupied holding register at or after rr_ptr_r.
    always_comb begin
        grant_any_s = 1'b0;
        grant_idx_s = {LANE_W{1'b0}};
        grant_vec_s = {NMVU{1'b0}};
        idx_s       = 0;
        lane_s      = {LANE_W{1'b0}};
        hit_s       = 1'b0;
        for (int k = 0; k < NMVU; k++) begin
            idx_s       = (int'(rr_ptr_r) + k) % NMVU;
            lane_s      = LANE_W'(idx_s);
            hit_s       = hold_v_r[lane_s] && !grant_any_s && !fifo_full_s;
            grant_idx_s = hit_s ? lane_s : grant_idx_s;
            grant_vec_s[lane_s] = hit_s;
            grant_any_s = grant_any_s | hit_s;
        end
    end

    // Per-lane holding registers; a lane being granted can reload in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_v_r <= {NMVU{1'b0}};
            for (int i = 0; i < NMVU; i++) begin
                hold_addr_r[i] <= {ADDR_W{1'b0}};
                hold_data_r[i] <= {DATA_W{1'b0}};
            end
        end else if (start_s) begin
            hold_v_r <= {NMVU{1'b0}};
        end else begin
            for (int i = 0; i < NMVU; i++) begin
                if (cap_s[i] && (!hold_v_r[i] || grant_vec_s[i])) begin
                    hold_v_r[i]    <= 1'b1;
                    hold_addr_r[i] <= mvu_wr_addr[i*ADDR_W +: ADDR_W];
                    hold_data_r[i] <= mvu_wr_data[i*DATA_W +: DATA_W];
                end else if (grant_vec_s[i]) begin
                    hold_v_r[i] <= 1'b0;
                end else begin
                    hold_v_r[i] <= hold_v_r[i];
                end
            end
        end
    end

    // Priority pointer moves just past the most recently granted lane.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr_r <= {LANE_W{1'b0}};
        end else if (grant_any_s) begin
            rr_ptr_r <= (grant_idx_s == LANE_W'(NMVU - 1)) ? {LANE_W{1'b0}}
                                                            : grant_idx_s + LANE_W'(1);
        end else begin
            rr_ptr_r <= rr_ptr_r;
        end
    end

    // FIFO storage; contents are meaningless while the pointers say empty.
    always_ff @(posedge clk) begin
        if (grant_any_s) begin
            mem_r[wr_ptr_r[PTR_W-1:0]] <= {grant_idx_s, hold_addr_r[grant_idx_s],
                                           hold_data_r[grant_idx_s]};
        end
    end

    // FIFO pointers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r <= {(PTR_W+1){1'b0}};
            rd_ptr_r <= {(PTR_W+1){1'b0}};
        end else begin
            wr_ptr_r <= grant_any_s ? wr_ptr_r + (PTR_W+1)'(1) : wr_ptr_r;
            rd_ptr_r <= pop_s       ? rd_ptr_r + (PTR_W+1)'(1) : rd_ptr_r;
        end
    end

    // Collected-word counter, saturating, held after done until the next start.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= {CNT_W{1'b0}};
        end else if (start_s) begin
            count <= {CNT_W{1'b0}};
        end else if (grant_any_s && (count != {CNT_W{1'b1}})) begin
            count <= count + CNT_W'(1);
        end else begin
            count <= count;
        end
    end

    // Job sequencing FSM with registered status outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= S_IDLE;
            mask_r     <= {NMVU{1'b0}};
            irq_seen_r <= {NMVU{1'b0}};
            busy       <= 1'b0;
            done       <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    done <= 1'b0;
                    if (cfg_start) begin
                        state_r    <= S_COLLECT;
                        mask_r     <= cfg_mask;
                        irq_seen_r <= {NMVU{1'b0}};
                        overflow   <= 1'b0;
                        busy       <= 1'b1;
                    end else begin
                        state_r <= S_IDLE;
                    end
                end
                S_COLLECT: begin
                    irq_seen_r <= irq_seen_r | (mvu_irq & mask_r);
                    overflow   <= overflow | drop_s;
                    if (((irq_seen_r & mask_r) == mask_r) && (hold_v_r == {NMVU{1'b0}})) begin
                        state_r <= S_DRAIN;
                    end else begin
                        state_r <= S_COLLECT;
                    end
                end
                S_DRAIN: begin
                    if (fifo_empty_s) begin
                        state_r <= S_DONE;
                        done    <= 1'b1;
                    end else begin
                        state_r <= S_DRAIN;
                    end
                end
                S_DONE: begin
                    state_r <= S_IDLE;
                    done    <= 1'b0;
                    busy    <= 1'b0;
                end
                default: begin
                    state_r <= S_IDLE;
                    done    <= 1'b0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mvu_result_collector.sv
// Directed bench for mvu_result_collector: expected head words are queued as the
// lanes write and compared as the host pops them.
module tb_mvu_result_collector;
    localparam int NMVU   = 8;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 15;
    localparam int LANE_W = 3;
    localparam int CNT_W  = 16;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   cfg_start;
    logic [NMVU-1:0]        cfg_mask;
    logic [NMVU-1:0]        mvu_wr_en;
    logic [NMVU*ADDR_W-1:0] mvu_wr_addr;
    logic [NMVU*DATA_W-1:0] mvu_wr_data;
    logic [NMVU-1:0]        mvu_irq;
    logic                   busy;
    logic                   done;
    logic                   overflow;
    logic [CNT_W-1:0]       count;

    int          n_assert = 0;
    int          n_fail   = 0;
    logic [63:0] sb [$];
    logic [63:0] mon_exp;

    mvu_result_collector_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .LANE_W(LANE_W)) out_bus ();

    mvu_result_collector #(
        .NMVU(NMVU), .DATA_W(DATA_W), .ADDR_W(ADDR_W),
        .FIFO_DEPTH(16), .CNT_W(CNT_W), .LANE_W(LANE_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .cfg_start   (cfg_start),
        .cfg_mask    (cfg_mask),
        .mvu_wr_en   (mvu_wr_en),
        .mvu_wr_addr (mvu_wr_addr),
        .mvu_wr_data (mvu_wr_data),
        .mvu_irq     (mvu_irq),
        .out_if      (out_bus.master),
        .busy        (busy),
        .done        (done),
        .overflow    (overflow),
        .count       (count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] ent(input int lane, input int addr, input int data);
        return {14'd0, LANE_W'(lane), ADDR_W'(addr), DATA_W'(data)};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_wr(input int lane, input int addr, input int data);
        mvu_wr_en[lane] = 1'b1;
        mvu_wr_addr[lane*ADDR_W +: ADDR_W] = ADDR_W'(addr);
        mvu_wr_data[lane*DATA_W +: DATA_W] = DATA_W'(data);
    endtask

    task automatic start_job(input logic [NMVU-1:0] mask);
        cfg_mask  = mask;
        cfg_start = 1'b1;
        tick();
        cfg_start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int n;
        n = 0;
        while (!done && n < budget) begin
            tick();
            n++;
        end
        chk({tag, "_done"}, 64'(done), 64'd1);
        tick();
        chk({tag, "_done_one_cycle"}, 64'(done), 64'd0);
        chk({tag, "_idle"}, 64'(busy), 64'd0);
    endtask

    // Scoreboard: every host handshake must match the oldest expected word.
    always @(negedge clk) begin
        if (!rst && out_bus.out_valid && out_bus.out_ready) begin
            if (sb.size() == 0) begin
                chk("pop_unexpected", 64'(sb.size()), 64'd1);
            end else begin
                mon_exp = sb.pop_front();
                chk("pop", {14'd0, out_bus.out_lane, out_bus.out_addr, out_bus.out_data}, mon_exp);
            end
        end
    end

    initial begin
        rst = 1'b1;
        cfg_start = 1'b0;
        cfg_mask = '0;
        mvu_wr_en = '0;
        mvu_wr_addr = '0;
        mvu_wr_data = '0;
        mvu_irq = '0;
        out_bus.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", 64'(out_bus.out_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_ovf", 64'(overflow), 64'd0);
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_data", 64'(out_bus.out_data), 64'd0);
        rst = 1'b0;
        tick();

        // Contention: lanes 0 and 2 write together twice, interleaved round-robin.
        out_bus.out_ready = 1'b1;
        start_job(8'h05);
        chk("cont_busy", 64'(busy), 64'd1);
        drive_wr(0, 0, 32'hA000_0000);
        drive_wr(2, 0, 32'hB000_0000);
        sb.push_back(ent(0, 0, 32'hA000_0000));
        sb.push_back(ent(2, 0, 32'hB000_0000));
        tick();
        mvu_wr_en = '0;
        tick();
        drive_wr(0, 1, 32'hA000_0001);
        drive_wr(2, 1, 32'hB000_0001);
        sb.push_back(ent(0, 1, 32'hA000_0001));
        sb.push_back(ent(2, 1, 32'hB000_0001));
        tick();
        mvu_wr_en = '0;
        mvu_irq = 8'h05;
        tick();
        mvu_irq = '0;
        wait_done("cont", 50);
        chk("cont_count", 64'(count), 64'd4);
        chk("cont_ovf", 64'(overflow), 64'd0);
        chk("cont_sb_empty", 64'(sb.size()), 64'd0);

        // Single lane: three words, two-cycle latency to out_valid.
        start_job(8'h01);
        drive_wr(0, 0, 32'h0000_00AA);
        sb.push_back(ent(0, 0, 32'h0000_00AA));
        tick();
        chk("lat_held", 64'(out_bus.out_valid), 64'd0);
        drive_wr(0, 1, 32'h0000_00BB);
        sb.push_back(ent(0, 1, 32'h0000_00BB));
        tick();
        chk("lat_valid", 64'(out_bus.out_valid), 64'd1);
        drive_wr(0, 2, 32'h0000_00CC);
        sb.push_back(ent(0, 2, 32'h0000_00CC));
        tick();
        mvu_wr_en = '0;
        mvu_irq = 8'h01;
        tick();
        mvu_irq = '0;
        wait_done("single", 50);
        chk("single_count", 64'(count), 64'd3);
        chk("single_sb_empty", 64'(sb.size()), 64'd0);

        // Backpressure: 20 writes into a full path; 16 in FIFO, 1 held, rest dropped.
        out_bus.out_ready = 1'b0;
        start_job(8'h02);
        for (int i = 0; i < 20; i++) begin
            drive_wr(1, i, 32'h0000_1000 + i);
            if (i < 17) sb.push_back(ent(1, i, 32'h0000_1000 + i));
            tick();
        end
        mvu_wr_en = '0;
        tick();
        chk("bp_ovf", 64'(overflow), 64'd1);
        chk("bp_count_full", 64'(count), 64'd16);
        chk("bp_head_lane", 64'(out_bus.out_lane), 64'd1);
        chk("bp_head_data", 64'(out_bus.out_data), 64'h1000);
        mvu_irq = 8'h02;
        tick();
        mvu_irq = '0;
        tick();
        chk("bp_head_stable", 64'(out_bus.out_data), 64'h1000);
        chk("bp_busy", 64'(busy), 64'd1);
        out_bus.out_ready = 1'b1;
        wait_done("bp", 100);
        chk("bp_count", 64'(count), 64'd17);
        chk("bp_sb_empty", 64'(sb.size()), 64'd0);
        chk("bp_empty_data", 64'(out_bus.out_data), 64'd0);
        chk("bp_ovf_sticky", 64'(overflow), 64'd1);

        // Masking: lane 3 is ignored, a start while busy changes nothing.
        start_job(8'h02);
        chk("mask_ovf_cleared", 64'(overflow), 64'd0);
        drive_wr(3, 5, 32'hDEAD_0003);
        tick();
        drive_wr(3, 6, 32'hDEAD_0004);
        mvu_irq = 8'h08;
        tick();
        mvu_wr_en = '0;
        mvu_irq = '0;
        cfg_start = 1'b1;
        cfg_mask = 8'hFF;
        tick();
        cfg_start = 1'b0;
        chk("mask_busy", 64'(busy), 64'd1);
        mvu_irq = 8'h02;
        tick();
        mvu_irq = '0;
        wait_done("mask", 30);
        chk("mask_count", 64'(count), 64'd0);
        chk("mask_sb_empty", 64'(sb.size()), 64'd0);

        // Empty mask: done two cycles after the start edge.
        start_job(8'h00);
        chk("empty_done_s0", 64'(done), 64'd0);
        tick();
        chk("empty_done_s1", 64'(done), 64'd0);
        tick();
        chk("empty_done_s2", 64'(done), 64'd1);
        chk("empty_busy_s2", 64'(busy), 64'd1);
        tick();
        chk("empty_done_s3", 64'(done), 64'd0);
        chk("empty_busy_s3", 64'(busy), 64'd0);

        // Reset mid-job with five words buffered.
        out_bus.out_ready = 1'b0;
        start_job(8'h01);
        for (int i = 0; i < 5; i++) begin
            drive_wr(0, i, 32'h0000_5000 + i);
            tick();
        end
        mvu_wr_en = '0;
        tick();
        tick();
        chk("rj_count_pre", 64'(count), 64'd5);
        #2;
        rst = 1'b1;
        #1;
        chk("rj_valid", 64'(out_bus.out_valid), 64'd0);
        chk("rj_busy", 64'(busy), 64'd0);
        chk("rj_count", 64'(count), 64'd0);
        tick();
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("rj_no_done", 64'(done), 64'd0);
        end
        chk("rj_still_empty", 64'(out_bus.out_valid), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
